// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the two RAM requesters (CPU, DMA), the arbiter and the
// nibble-wide X/Y RAM arrays. The arbiter takes the slave view.
interface ram_port_arbiter_if #(
  parameter int AW = 15
);
  logic          cpu_req;
  logic          cpu_we;
  logic [1:0]    cpu_sel;
  logic [AW-1:0] cpu_addr;
  logic [3:0]    cpu_wdata;
  logic          cpu_ack;

  logic          dma_req;
  logic          dma_we;
  logic [1:0]    dma_sel;
  logic [AW-1:0] dma_addr;
  logic [3:0]    dma_wdata;
  logic          dma_ack;

  logic [7:0]    rdata;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_data;
  logic          ram_wren_x;
  logic          ram_wren_y;
  logic          ram_rden;
  logic [3:0]    ram_q_x;
  logic [3:0]    ram_q_y;
  logic          busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_sel, cpu_addr, cpu_wdata,
    output cpu_ack,
    input  dma_req, dma_we, dma_sel, dma_addr, dma_wdata,
    output dma_ack,
    output rdata, ram_addr, ram_data, ram_wren_x, ram_wren_y, ram_rden, busy,
    input  ram_q_x, ram_q_y
  );

  modport master (
    output cpu_req, cpu_we, cpu_sel, cpu_addr, cpu_wdata,
    input  cpu_ack,
    output dma_req, dma_we, dma_sel, dma_addr, dma_wdata,
    input  dma_ack,
    input  rdata, ram_addr, ram_data, ram_wren_x, ram_wren_y, ram_rden, busy,
    output ram_q_x, ram_q_y
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Serialises CPU and DMA accesses onto the shared X/Y nibble RAM: one access
// per IDLE->ISSUE->(WAIT)->DONE pass, DMA forced in after STARVE_MAX CPU wins.
module ram_port_arbiter #(
  parameter int AW         = 15,
  parameter int STARVE_MAX = 3
) (
  input  logic                ram_clk,
  input  logic                rst,
  ram_port_arbiter_if.slave   io_bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_streak;
  logic [2:0]    w_streak_nxt;

  logic          r_grant_dma;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [3:0]    r_data;
  logic          r_wren_x;
  logic          r_wren_y;
  logic          r_rden;
  logic [7:0]    r_rdata;
  logic          r_cpu_ack;
  logic          r_dma_ack;

  logic          w_load;
  logic          w_pick_dma;
  logic          w_capture;
  logic          w_finish;
  logic          w_to_done;

  logic          w_we;
  logic [1:0]    w_sel;
  logic [AW-1:0] w_addr;
  logic [3:0]    w_wdata;

  always_ff @(posedge ram_clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_streak <= 3'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_streak_nxt = r_streak;
    w_load       = 1'b0;
    w_pick_dma   = 1'b0;
    w_capture    = 1'b0;
    w_finish     = 1'b0;
    w_to_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_bus.cpu_req || io_bus.dma_req) begin
          w_load      = 1'b1;
          w_state_nxt = S_ISSUE;
          w_pick_dma  = io_bus.dma_req &&
                        (!io_bus.cpu_req || (r_streak == STARVE_LIM));
          // Streak only grows while DMA is actually being made to wait.
          if (w_pick_dma || !io_bus.dma_req)
            w_streak_nxt = 3'd0;
          else if (r_streak != 3'd7)
            w_streak_nxt = r_streak + 3'd1;
        end
      end
      S_ISSUE: begin
        if (r_we) begin
          w_state_nxt = S_DONE;
          w_to_done   = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_capture   = 1'b1;
        w_to_done   = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_finish    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_we    = io_bus.cpu_we;
    w_sel   = io_bus.cpu_sel;
    w_addr  = io_bus.cpu_addr;
    w_wdata = io_bus.cpu_wdata;
    if (w_pick_dma) begin
      w_we    = io_bus.dma_we;
      w_sel   = io_bus.dma_sel;
      w_addr  = io_bus.dma_addr;
      w_wdata = io_bus.dma_wdata;
    end
  end

  // RAM-side registers: loaded at grant, held through DONE, enables cleared
  // on leaving DONE. Reset aborts any access in flight without an ack.
  always_ff @(posedge ram_clk) begin
    if (rst) begin
      r_grant_dma <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_data      <= 4'd0;
      r_wren_x    <= 1'b0;
      r_wren_y    <= 1'b0;
      r_rden      <= 1'b0;
      r_rdata     <= 8'd0;
      r_cpu_ack   <= 1'b0;
      r_dma_ack   <= 1'b0;
    end else begin
      r_cpu_ack <= w_to_done & ~r_grant_dma;
      r_dma_ack <= w_to_done &  r_grant_dma;
      if (w_load) begin
        r_grant_dma <= w_pick_dma;
        r_we        <= w_we;
        r_addr      <= w_addr;
        r_data      <= w_wdata;
        r_wren_x    <= w_we & w_sel[0];
        r_wren_y    <= w_we & w_sel[1];
        r_rden      <= ~w_we;
      end else if (w_finish) begin
        r_wren_x    <= 1'b0;
        r_wren_y    <= 1'b0;
        r_rden      <= 1'b0;
      end
      if (w_capture)
        r_rdata <= {io_bus.ram_q_y, io_bus.ram_q_x};
    end
  end

  assign io_bus.cpu_ack    = r_cpu_ack;
  assign io_bus.dma_ack    = r_dma_ack;
  assign io_bus.rdata      = r_rdata;
  assign io_bus.ram_addr   = r_addr;
  assign io_bus.ram_data   = r_data;
  assign io_bus.ram_wren_x = r_wren_x;
  assign io_bus.ram_wren_y = r_wren_y;
  assign io_bus.ram_rden   = r_rden;
  assign io_bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: stimulus pushes expected responses
// per port, a negedge monitor checks them whenever an ack appears.
module tb_ram_port_arbiter;

  localparam int AW = 15;

  typedef struct {
    bit          we;
    logic [1:0]  sel;
    logic [14:0] addr;
    logic [3:0]  wdata;
    logic [7:0]  rdata;
    int          exp_cyc;
  } item_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_tests;
  int   n_fail;

  item_t       q_cpu[$];
  item_t       q_dma[$];
  bit          grant_log[$];
  bit          log_en;
  logic [7:0]  last_rd;

  logic [3:0]  mem_x [0:32767];
  logic [3:0]  mem_y [0:32767];

  ram_port_arbiter_if #(.AW(AW)) bus ();

  ram_port_arbiter #(.AW(AW), .STARVE_MAX(3)) dut (
    .ram_clk (clk),
    .rst     (rst),
    .io_bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // X/Y nibble arrays with one-cycle synchronous read
  always @(posedge clk) begin
    if (bus.ram_wren_x) mem_x[bus.ram_addr] <= bus.ram_data;
    if (bus.ram_wren_y) mem_y[bus.ram_addr] <= bus.ram_data;
    bus.ram_q_x <= mem_x[bus.ram_addr];
    bus.ram_q_y <= mem_y[bus.ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the expected item of whichever port acks
  initial begin
    item_t it;
    bit    port;
    bit    chk_drop;
    string p;
    chk_drop = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_drop)
        chk("en_drop", {29'd0, bus.ram_wren_x, bus.ram_wren_y, bus.ram_rden}, 32'd0);
      chk_drop = 1'b0;
      if (bus.cpu_ack || bus.dma_ack) begin
        chk("ack_onehot", {31'd0, bus.cpu_ack & bus.dma_ack}, 32'd0);
        port = bus.dma_ack;
        p    = port ? "dma" : "cpu";
        if ((port && q_dma.size() == 0) || (!port && q_cpu.size() == 0)) begin
          n_tests++;
          n_fail++;
          $display("FAIL %s_unexpected_ack: got ack, expected none (cycle %0d)", p, cyc);
        end else begin
          it = port ? q_dma.pop_front() : q_cpu.pop_front();
          chk({p, "_addr"}, {17'd0, bus.ram_addr}, {17'd0, it.addr});
          chk({p, "_wren"}, {30'd0, bus.ram_wren_y, bus.ram_wren_x},
              it.we ? {30'd0, it.sel} : 32'd0);
          chk({p, "_rden"}, {31'd0, bus.ram_rden}, {31'd0, ~it.we});
          if (it.we) begin
            chk({p, "_wdata"}, {28'd0, bus.ram_data}, {28'd0, it.wdata});
            chk({p, "_rdata_hold"}, {24'd0, bus.rdata}, {24'd0, last_rd});
          end else begin
            chk({p, "_rdata"}, {24'd0, bus.rdata}, {24'd0, it.rdata});
            last_rd = it.rdata;
          end
          if (it.exp_cyc >= 0)
            chk({p, "_latency"}, cyc, it.exp_cyc);
          if (log_en) grant_log.push_back(port);
          chk_drop = 1'b1;
        end
      end
    end
  end

  task automatic access(input bit dma, input bit we, input logic [1:0] sel,
                        input logic [14:0] addr, input logic [3:0] wd,
                        input logic [7:0] exp_rd, input bit lat);
    item_t it;
    bit    got;
    got        = 1'b0;
    it.we      = we;
    it.sel     = sel;
    it.addr    = addr;
    it.wdata   = wd;
    it.rdata   = exp_rd;
    it.exp_cyc = lat ? cyc + (we ? 2 : 3) : -1;
    if (dma) begin
      q_dma.push_back(it);
      bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_sel = sel;
      bus.dma_addr = addr; bus.dma_wdata = wd;
    end else begin
      q_cpu.push_back(it);
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_sel = sel;
      bus.cpu_addr = addr; bus.cpu_wdata = wd;
    end
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (dma ? bus.dma_ack : bus.cpu_ack) begin
        got = 1'b1;
        break;
      end
    end
    chk(dma ? "dma_ack_seen" : "cpu_ack_seen", {31'd0, got}, 32'd1);
    @(negedge clk);
    if (dma) bus.dma_req = 1'b0;
    else     bus.cpu_req = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ctrl"}, {26'd0, bus.busy, bus.cpu_ack, bus.dma_ack,
                         bus.ram_wren_x, bus.ram_wren_y, bus.ram_rden}, 32'd0);
    chk({tag, "_addr"}, {17'd0, bus.ram_addr}, 32'd0);
    chk({tag, "_data"}, {20'd0, bus.ram_data, bus.rdata}, 32'd0);
  endtask

  initial begin
    bit exp_order [11];
    exp_order = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1};
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    log_en  = 1'b0;
    last_rd = 8'd0;
    for (int i = 0; i < 32768; i++) begin
      mem_x[i] = 4'd0;
      mem_y[i] = 4'd0;
    end
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_sel = 2'd0;
    bus.cpu_addr = '0;  bus.cpu_wdata = 4'd0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_sel = 2'd0;
    bus.dma_addr = '0;  bus.dma_wdata = 4'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single-port reads and writes
    access(0, 1, 2'b01, 15'h0123, 4'hA, 8'h00, 1);
    access(0, 0, 2'b01, 15'h0123, 4'h0, 8'h0A, 1);
    access(0, 1, 2'b11, 15'h0200, 4'h5, 8'h00, 1);
    access(1, 0, 2'b11, 15'h0200, 4'h0, 8'h55, 1);
    access(0, 1, 2'b10, 15'h0123, 4'h3, 8'h00, 1);
    access(0, 0, 2'b01, 15'h0123, 4'h0, 8'h3A, 1);

    // DMA alone, including a write with no nibble selected
    access(1, 1, 2'b00, 15'h0300, 4'hF, 8'h00, 1);
    access(1, 1, 2'b01, 15'h0301, 4'h6, 8'h00, 1);
    access(1, 1, 2'b10, 15'h0302, 4'h9, 8'h00, 1);
    access(1, 0, 2'b11, 15'h0300, 4'h0, 8'h00, 1);
    access(1, 0, 2'b11, 15'h0302, 4'h0, 8'h90, 1);
    access(0, 0, 2'b11, 15'h0301, 4'h0, 8'h06, 1);

    // Both ports streaming: starvation guard forces every fourth grant to DMA
    log_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++)
          access(0, 1, 2'b11, 15'h1000 + 15'(i), 4'(i), 8'h00, 0);
      end
      begin
        for (int j = 0; j < 3; j++)
          access(1, 1, 2'b11, 15'h2000 + 15'(j), 4'(j + 8), 8'h00, 0);
      end
    join
    log_en = 1'b0;
    chk("grant_count", grant_log.size(), 11);
    for (int i = 0; i < 11 && i < grant_log.size(); i++)
      chk($sformatf("grant_order_%0d", i), {31'd0, grant_log[i]}, {31'd0, exp_order[i]});

    // Reset while a CPU read sits in WAIT: aborted, no ack
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_sel = 2'b11;
    bus.cpu_addr = 15'h0123; bus.cpu_wdata = 4'd0;
    @(negedge clk);
    @(negedge clk);
    chk("busy_in_wait", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk_reset_state("abort");
    last_rd = 8'd0;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    access(0, 0, 2'b11, 15'h1003, 4'h0, 8'h33, 1);
    access(1, 0, 2'b01, 15'h2002, 4'h0, 8'hAA, 1);

    repeat (3) @(negedge clk);
    chk("cpu_queue_empty", q_cpu.size(), 0);
    chk("dma_queue_empty", q_dma.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
